tone_pwm_synth: RTL
===================

# tone_pwm_synth

Parametrised multi-channel tone synthesiser with a PWM audio output for the board's mono audio jack. It generalises the single-tone audio PWM top level to NUM_CH channels, each with its own phase accumulator, waveform mode and volume, programmed through a register write port. Channels are mixed and modulated into one PWM bit-stream. It sits between the board-level top (clock, button reset, switch enable, AUD_PWM/AUD_SD pins) and any sequencer logic that drives the configuration port.

## Interface
- NUM_CH, 4: channel count; power of two, 1..8
- PHASE_W, 24: phase accumulator and tuning word width
- SAMPLE_W, 8: sample and PWM resolution; the PWM period is 2^SAMPLE_W clocks; ≥3
- VOL_W, 4: per-channel volume width
- CLK100MHZ  in  1  system clock, 100 MHz
- BTNC  in  1  reset; one clock; reset is synchronous and active-high
- SW  in  1  audio enable
- cfg_we  in  1  config write strobe, one cycle per write
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_sel  in  2  field: 0 tuning word, 1 mode, 2 volume, 3 phase reset
- cfg_data  in  PHASE_W  write data; the field uses its LSBs
- AUD_PWM  out  1  PWM audio bit
- AUD_SD  out  1  amplifier enable (1 = on)

## Operation
- PWM counter `cnt` (SAMPLE_W bits) increments every clock and wraps. The sample boundary is the cycle with cnt == 2^SAMPLE_W−1.
- Per channel, the block holds shadow registers (tw, mode[1:0], vol, prst) and active registers. cfg_we writes the addressed shadow field. sel 3 sets prst. An out-of-range cfg_ch is ignored.
- At the boundary:
  - shadows are copied to the active registers; a write in the boundary cycle itself is included (bypass)
  - each phase becomes 0 if prst is set (prst then clears), else phase + tw_active (mod 2^PHASE_W)
  - duty is loaded from the mix register
- Waveform from top bits of phase, p = phase[PHASE_W−1 -: SAMPLE_W]:
  - mode 0 square: p MSB ? all-ones : 0
  - mode 1 saw: p
  - mode 2 triangle: MSB ? ~{p[SAMPLE_W−2:0],0} : {p[SAMPLE_W−2:0],0}
  - mode 3 off: 0
- Scale: s = (w × (vol+1)) >> VOL_W. Max volume is unity gain; vol 0 gives w/2^VOL_W. Mute uses mode 3.
- Mix: m = (Σ s) >> log2(NUM_CH). There is no overflow or clipping by construction.
- Output:
  - AUD_PWM = en_q & (cnt < duty). Duty 0 gives a constant 0; the maximum duty gives high for 2^SAMPLE_W−1 of 2^SAMPLE_W clocks.
  - en_q samples SW only at the boundary, so there are no truncated pulses. AUD_SD = en_q.
  - Phases keep running while disabled.

## Timing
- Pipeline, all registered every cycle: wave (stage 1) → scaled (stage 2) → mix (stage 3). It settles 3 cycles after a phase update, well before the next boundary.
- Latency: a config write during period k is committed at the end of period k. It affects the phases that drive the mix during period k+1, and appears in duty and AUD_PWM in period k+2.
- SW change during period k → AUD_PWM/AUD_SD change at the first cycle of period k+1.
- BTNC during operation: on the next clock, all registers clear, including shadows, and the counter restarts at 0.
- Reset values:
  - cnt 0, phases 0, tw 0, mode 3, vol 0, prst 0
  - pipeline registers 0, duty 0, en_q 0
  - AUD_PWM 0, AUD_SD 0
- Simultaneous prst and tw write to one channel in the same period: the phase goes to 0 at the boundary and the new tw applies from the following boundary.
- Two writes to the same field within one period: the last one wins.

## Structure
- Package tone_pwm_pkg holds:
  - the mode enum (SQUARE, SAW, TRI, OFF)
  - cfg_sel field constants
  - the channel config struct {tw, mode, vol}
- Sub-module tone_channel: shadow/active registers, phase accumulator, stage-1/2 waveform and scale. It is instantiated NUM_CH times.
- The top level holds cnt, the mixer, the duty register and the enable gating.

## Test plan
- Reset: hold BTNC 20 cycles with SW=1 → AUD_PWM=0 and AUD_SD=0; after release, AUD_PWM stays 0 (all channels off) for 4 periods.
- Single square, defaults: ch0 tw=2^21, mode 0, vol 15; SW=1 → duty alternates 63 for 4 periods and 0 for 4 periods (8-sample cycle); AUD_PWM high exactly 63 clocks per high period.
- Full mix: all 4 channels tw=0, mode 0, vol 15, phase reset to 0 then tw=2^23 (phase MSB set after one boundary) → duty 255; AUD_PWM low exactly 1 clock per period.
- Latency: write ch0 vol in period k (including the boundary cycle) → the duty change first appears in period k+2, not earlier.
- Enable gating: drop SW mid-period → pulses in the current period complete, AUD_PWM/AUD_SD go 0 at the next period start; raising SW restores them at a period start.
- Phase reset with simultaneous tw write, then BTNC mid-period: the phase is 0 at the boundary and the new tw applies a boundary later; BTNC clears everything within 1 clock.

Source files
------------

// File: rtl/tone_pwm_pkg.sv
// Shared types and constants for the multi-channel tone PWM synthesiser.
//   mode_e    : per-channel waveform select (square, saw, triangle, off)
//   SEL_*     : cfg_sel field codes for the configuration write port
//   ch_cfg_t  : per-channel configuration record {tw, mode, vol}
// The record is sized for the widest supported build (PHASE_W <= 32,
// VOL_W <= 8); each channel only uses the low bits of tw and vol.
package tone_pwm_pkg;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    OFF    = 2'd3
  } mode_e;

  localparam logic [1:0] SEL_TW   = 2'd0;
  localparam logic [1:0] SEL_MODE = 2'd1;
  localparam logic [1:0] SEL_VOL  = 2'd2;
  localparam logic [1:0] SEL_PRST = 2'd3;

  localparam int CFG_TW_MAX_W  = 32;
  localparam int CFG_VOL_MAX_W = 8;

  typedef struct packed {
    logic [CFG_TW_MAX_W-1:0]  tw;
    mode_e                    mode;
    logic [CFG_VOL_MAX_W-1:0] vol;
  } ch_cfg_t;

  localparam ch_cfg_t CH_CFG_RESET = '{tw: '0, mode: OFF, vol: '0};

endpackage

// File: rtl/tone_pwm_synth_channel.sv
// tone_channel: one synthesiser voice.
// Holds the shadow and active configuration, the phase accumulator, and the
// first two pipeline stages (waveform, volume scale).
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_boundary    : high in the last cycle of each PWM period
//   i_we          : write strobe already decoded for this channel
//   i_sel, i_data : field select and write data
//   o_scaled      : stage-2 registered, volume-scaled sample
module tone_channel
  import tone_pwm_pkg::*;
#(
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_boundary,
  input  logic                i_we,
  input  logic [1:0]          i_sel,
  input  logic [PHASE_W-1:0]  i_data,
  output logic [SAMPLE_W-1:0] o_scaled
);

  localparam int PROD_W = SAMPLE_W + VOL_W;

  ch_cfg_t               r_shadow;
  ch_cfg_t               r_active;
  logic                  r_prst;
  logic [PHASE_W-1:0]    r_phase;
  logic [SAMPLE_W-1:0]   r_wave;
  logic [SAMPLE_W-1:0]   r_scaled;

  ch_cfg_t               w_next;
  logic                  w_prst_next;
  logic [SAMPLE_W-1:0]   w_p;
  logic [SAMPLE_W-1:0]   w_tri_base;
  logic [SAMPLE_W-1:0]   w_wave;
  logic [VOL_W:0]        w_vol_p1;
  logic [PROD_W-1:0]     w_prod;
  logic [SAMPLE_W-1:0]   w_scaled;
  logic                  w_unused_hi;

  // Shadow as it will be after this cycle's write; the boundary copies this
  // so a write landing in the boundary cycle is not lost.
  always_comb begin
    w_next = r_shadow;
    if (i_we) begin
      case (i_sel)
        SEL_TW:   w_next.tw   = CFG_TW_MAX_W'(i_data);
        SEL_MODE: w_next.mode = mode_e'(i_data[1:0]);
        SEL_VOL:  w_next.vol  = CFG_VOL_MAX_W'(i_data[VOL_W-1:0]);
        default:  ;
      endcase
    end
  end

  assign w_prst_next = r_prst | (i_we && (i_sel == SEL_PRST));

  assign w_p        = r_phase[PHASE_W-1 -: SAMPLE_W];
  assign w_tri_base = {w_p[SAMPLE_W-2:0], 1'b0};

  always_comb begin
    w_wave = '0;
    case (r_active.mode)
      SQUARE:  w_wave = {SAMPLE_W{w_p[SAMPLE_W-1]}};
      SAW:     w_wave = w_p;
      TRI:     w_wave = w_p[SAMPLE_W-1] ? ~w_tri_base : w_tri_base;
      default: w_wave = '0;
    endcase
  end

  // vol+1 makes full-scale volume an exact unity gain after the shift.
  assign w_vol_p1 = (VOL_W+1)'(r_active.vol[VOL_W-1:0]) + (VOL_W+1)'(1);
  assign w_prod   = PROD_W'(r_wave) * PROD_W'(w_vol_p1);
  assign w_scaled = SAMPLE_W'(w_prod >> VOL_W);

  // Upper bits of the wide config record are always zero in this build.
  assign w_unused_hi = ^{r_active.tw, r_active.vol};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= CH_CFG_RESET;
      r_active <= CH_CFG_RESET;
      r_prst   <= 1'b0;
      r_phase  <= '0;
      r_wave   <= '0;
      r_scaled <= '0;
    end else begin
      r_shadow <= w_next;
      if (i_boundary) begin
        r_active <= w_next;
        r_prst   <= 1'b0;
        // A pending phase reset wins; the new tuning word then takes
        // effect from the following boundary.
        r_phase  <= w_prst_next ? '0 : r_phase + w_next.tw[PHASE_W-1:0];
      end else begin
        r_prst   <= w_prst_next;
      end
      r_wave   <= w_wave;
      r_scaled <= w_scaled;
    end
  end

  assign o_scaled = r_scaled;

endmodule

// File: rtl/tone_pwm_synth.sv
// tone_pwm_synth: NUM_CH-voice tone synthesiser driving a single PWM pin.
// Holds the PWM counter, the channel mixer (stage 3), the duty register and
// the enable gating; voices live in tone_channel instances.
// Ports:
//   CLK100MHZ : system clock
//   BTNC      : synchronous active-high reset
//   SW        : audio enable, sampled once per PWM period
//   cfg_we, cfg_ch, cfg_sel, cfg_data : configuration write port
//   AUD_PWM   : PWM audio bit
//   AUD_SD    : amplifier enable
module tone_pwm_synth
  import tone_pwm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 4
) (
  input  logic                                       CLK100MHZ,
  input  logic                                       BTNC,
  input  logic                                       SW,
  input  logic                                       cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                 cfg_sel,
  input  logic [PHASE_W-1:0]                         cfg_data,
  output logic                                       AUD_PWM,
  output logic                                       AUD_SD
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LOG2  = $clog2(NUM_CH);
  localparam int SUM_W = SAMPLE_W + LOG2;

  logic [SAMPLE_W-1:0] r_cnt;
  logic [SAMPLE_W-1:0] r_mix;
  logic [SAMPLE_W-1:0] r_duty;
  logic                r_en;

  logic                w_boundary;
  logic [NUM_CH-1:0]   w_we;
  logic [SAMPLE_W-1:0] w_scaled [NUM_CH];
  logic [SUM_W-1:0]    w_sum;

  assign w_boundary = (r_cnt == '1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Channel indices with no instance never match, so such writes drop.
    assign w_we[g] = cfg_we && (cfg_ch == CH_W'(g));

    tone_channel #(
      .PHASE_W  (PHASE_W),
      .SAMPLE_W (SAMPLE_W),
      .VOL_W    (VOL_W)
    ) u_ch (
      .i_clk      (CLK100MHZ),
      .i_rst      (BTNC),
      .i_boundary (w_boundary),
      .i_we       (w_we[g]),
      .i_sel      (cfg_sel),
      .i_data     (cfg_data),
      .o_scaled   (w_scaled[g])
    );
  end

  // Averaging by a power-of-two channel count keeps the mix in range.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = w_sum + SUM_W'(w_scaled[i]);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      r_cnt  <= '0;
      r_mix  <= '0;
      r_duty <= '0;
      r_en   <= 1'b0;
    end else begin
      r_cnt <= r_cnt + SAMPLE_W'(1);
      r_mix <= SAMPLE_W'(w_sum >> LOG2);
      // Duty and enable only move between periods so no pulse is cut short.
      if (w_boundary) begin
        r_duty <= r_mix;
        r_en   <= SW;
      end
    end
  end

  assign AUD_PWM = r_en & (r_cnt < r_duty);
  assign AUD_SD  = r_en;

endmodule
